// File: rtl/exception_sequencer.sv
// ============================================================================
// exception_sequencer : pipeline recovery sequencer (flush, redirect, return).
// Optional feature macro: EXC_VECTOR_EN (vectored handler entry by cause).
// Revision: 1.0
// ============================================================================
`default_nettype none

module exception_sequencer #(
    parameter int                  PC_WIDTH     = 16,
    parameter logic [PC_WIDTH-1:0] HANDLER_ADDR = 16'h0040,
    parameter logic [PC_WIDTH-1:0] VEC_STRIDE   = 16'h0008
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                exception_flag,
    input  logic [15:0]         instruct,
    input  logic [PC_WIDTH-1:0] pc_in,
    input  logic                stall,
    input  logic                eret,
    output logic                flush_if,
    output logic                flush_id,
    output logic                flush_ex,
    output logic                pc_sel,
    output logic [PC_WIDTH-1:0] pc_target,
    output logic [PC_WIDTH-1:0] epc,
    output logic [3:0]          cause,
    output logic                exc_active,
    output logic                halt,
    output logic [7:0]          exc_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FLUSH    = 3'd1,
        S_REDIRECT = 3'd2,
        S_HANDLER  = 3'd3,
        S_RETURN   = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [PC_WIDTH-1:0] r_epc;
    logic [3:0]          r_cause;
    logic [7:0]          r_exc_count;
    logic [PC_WIDTH-1:0] w_handler_target;
    logic                w_take;

    // Only the opcode field of the faulting instruction is recorded.
    logic w_unused_instruct;
    assign w_unused_instruct = ^instruct[11:0];

`ifdef EXC_VECTOR_EN
    assign w_handler_target = HANDLER_ADDR
                            + ({{(PC_WIDTH-4){1'b0}}, r_cause} * VEC_STRIDE);
`else
    assign w_handler_target = HANDLER_ADDR;
`endif

    assign w_take = (r_state == S_IDLE) && exception_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_epc       <= '0;
            r_cause     <= '0;
            r_exc_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_take) begin
                r_epc   <= pc_in;
                r_cause <= instruct[15:12];
                if (r_exc_count != 8'hFF) begin
                    r_exc_count <= r_exc_count + 8'd1;
                end
            end
        end
    end

    // Outputs decode from registered state only; no input-to-output paths.
    always_comb begin
        w_next_state = r_state;
        flush_if     = 1'b0;
        flush_id     = 1'b0;
        flush_ex     = 1'b0;
        pc_sel       = 1'b0;
        pc_target    = '0;
        exc_active   = 1'b0;
        halt         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (exception_flag) begin
                    w_next_state = S_FLUSH;
                end
            end
            S_FLUSH: begin
                flush_if     = 1'b1;
                flush_id     = 1'b1;
                flush_ex     = 1'b1;
                w_next_state = S_REDIRECT;
            end
            S_REDIRECT: begin
                pc_sel    = 1'b1;
                pc_target = w_handler_target;
                if (!stall) begin
                    w_next_state = S_HANDLER;
                end
            end
            S_HANDLER: begin
                exc_active = 1'b1;
                // A nested exception beats a simultaneous eret.
                if (exception_flag) begin
                    w_next_state = S_HALT;
                end else if (eret) begin
                    w_next_state = S_RETURN;
                end
            end
            S_RETURN: begin
                pc_sel     = 1'b1;
                pc_target  = r_epc;
                exc_active = 1'b1;
                if (!stall) begin
                    w_next_state = S_IDLE;
                end
            end
            S_HALT: begin
                halt     = 1'b1;
                flush_if = 1'b1;
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign epc       = r_epc;
    assign cause     = r_cause;
    assign exc_count = r_exc_count;

endmodule

`default_nettype wire

// File: tb/tb_exception_sequencer.sv
// ============================================================================
// tb_exception_sequencer : directed + random bench against a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_exception_sequencer;

    logic        clk;
    logic        rst;
    logic        exception_flag;
    logic [15:0] instruct;
    logic [15:0] pc_in;
    logic        stall;
    logic        eret;
    logic        flush_if, flush_id, flush_ex;
    logic        pc_sel;
    logic [15:0] pc_target;
    logic [15:0] epc;
    logic [3:0]  cause;
    logic        exc_active;
    logic        halt;
    logic [7:0]  exc_count;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: phase names, saved context, counter.
    string m_phase;
    int    m_epc;
    int    m_cause;
    int    m_count;

    exception_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .exception_flag (exception_flag),
        .instruct       (instruct),
        .pc_in          (pc_in),
        .stall          (stall),
        .eret           (eret),
        .flush_if       (flush_if),
        .flush_id       (flush_id),
        .flush_ex       (flush_ex),
        .pc_sel         (pc_sel),
        .pc_target      (pc_target),
        .epc            (epc),
        .cause          (cause),
        .exc_active     (exc_active),
        .halt           (halt),
        .exc_count      (exc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int handler_entry(input int c);
`ifdef EXC_VECTOR_EN
        return (16'h0040 + c * 16'h0008) % 65536;
`else
        return 16'h0040 + 0 * c;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = "idle";
        m_epc   = 0;
        m_cause = 0;
        m_count = 0;
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        if (m_phase == "idle") begin
            if (exception_flag) begin
                m_epc   = pc_in;
                m_cause = instruct / 4096;
                if (m_count < 255) m_count = m_count + 1;
                m_phase = "flush";
            end
        end else if (m_phase == "flush") begin
            m_phase = "redirect";
        end else if (m_phase == "redirect") begin
            if (!stall) m_phase = "handler";
        end else if (m_phase == "handler") begin
            if (exception_flag) m_phase = "halt";
            else if (eret)      m_phase = "return";
        end else if (m_phase == "return") begin
            if (!stall) m_phase = "idle";
        end
    endtask

    task automatic check_all(input string tag);
        logic fl, ps, act, hl;
        int   tgt;
        fl  = (m_phase == "flush") || (m_phase == "halt");
        ps  = (m_phase == "redirect") || (m_phase == "return");
        act = (m_phase == "handler") || (m_phase == "return");
        hl  = (m_phase == "halt");
        tgt = (m_phase == "redirect") ? handler_entry(m_cause) :
              (m_phase == "return")   ? m_epc : 0;
        check({tag, ".flush_if"},   32'(flush_if),   32'(fl));
        check({tag, ".flush_id"},   32'(flush_id),   32'(fl));
        check({tag, ".flush_ex"},   32'(flush_ex),   32'(fl));
        check({tag, ".pc_sel"},     32'(pc_sel),     32'(ps));
        check({tag, ".pc_target"},  32'(pc_target),  32'(tgt));
        check({tag, ".exc_active"}, 32'(exc_active), 32'(act));
        check({tag, ".halt"},       32'(halt),       32'(hl));
        check({tag, ".epc"},        32'(epc),        32'(m_epc));
        check({tag, ".cause"},      32'(cause),      32'(m_cause));
        check({tag, ".exc_count"},  32'(exc_count),  32'(m_count));
    endtask

    // Called at posedge+1; applies inputs, clocks once, checks at posedge+1.
    task automatic step(input string tag, input logic f, input logic e, input logic s,
                        input logic [15:0] ins, input logic [15:0] p);
        exception_flag = f;
        eret           = e;
        stall          = s;
        instruct       = ins;
        pc_in          = p;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Mid-cycle asynchronous reset; outputs must clear before any edge.
    task automatic async_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        exception_flag = 1'b0;
        eret = 1'b0;
        stall = 1'b0;
        instruct = 16'h0000;
        pc_in = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Eret while idle does nothing.
        step("idle_eret", 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);

        // Basic exception with a stalled redirect.
        step("take",  1'b1, 1'b0, 1'b0, 16'hB123, 16'h0010);
        check("take.epc_lit",   32'(epc),       32'h0010);
        check("take.cause_lit", 32'(cause),     32'hB);
        check("take.count_lit", 32'(exc_count), 32'h1);
        check("take.flush_lit", 32'(flush_ex),  32'h1);
        step("redir", 1'b1, 1'b0, 1'b1, 16'h7777, 16'h0999);
`ifdef EXC_VECTOR_EN
        check("redir.target_lit", 32'(pc_target), 32'h0098);
`else
        check("redir.target_lit", 32'(pc_target), 32'h0040);
`endif
        check("redir.flush_lit", 32'(flush_if), 32'h0);
        step("stall1", 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        step("stall2", 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        step("stall3", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("handler.active_lit", 32'(exc_active), 32'h1);
        step("hwait", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Eret returns to the saved PC, then idles.
        step("eret", 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        check("ret.target_lit", 32'(pc_target), 32'h0010);
        step("ret_stall", 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        step("ret_done",  1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check("ret.pc_sel_lit", 32'(pc_sel), 32'h0);

        // Double fault with simultaneous eret.
        step("t4.take", 1'b1, 1'b0, 1'b0, 16'h3000, 16'h0010);
        step("t4.f",    1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step("t4.r",    1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step("t4.dbl",  1'b1, 1'b1, 1'b0, 16'hF000, 16'h0077);
        check("t4.halt_lit", 32'(halt), 32'h1);
        check("t4.epc_lit",  32'(epc),  32'h0010);
        for (int i = 0; i < 6; i++) begin
            step("t4.sticky", 1'(i), 1'(i + 1), 1'(i / 2), 16'(i * 4099), 16'(i));
        end
        async_reset("t4.rst");

        // Asynchronous reset while in redirect.
        step("t6.take", 1'b1, 1'b0, 1'b0, 16'h2000, 16'h0123);
        step("t6.f",    1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        step("t6.r",    1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        async_reset("t6.rst");
        step("t6.idle", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Saturation of the exception counter.
        for (int i = 0; i < 260; i++) begin
            step("t5.take", 1'b1, 1'b0, 1'b0, 16'(i * 4096), 16'(i));
            step("t5.f",    1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            step("t5.r",    1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            step("t5.e",    1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
            step("t5.ret",  1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        end
        check("t5.sat_lit", 32'(exc_count), 32'hFF);

        // Random traffic; reset occasionally to escape halt.
        for (int i = 0; i < 600; i++) begin
            if (m_phase == "halt" && ($urandom % 4) == 0) begin
                async_reset("rnd.rst");
            end else begin
                step("rnd",
                     ($urandom % 4) == 0,
                     ($urandom % 3) == 0,
                     ($urandom % 2) == 0,
                     16'($urandom),
                     16'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
